// File: rtl/sram_wr_arb_pkg.sv
// Shared types and helpers for the SRAM write arbiter / front-end controller.
// The request struct is sized for the widest supported configuration.
package sram_wr_arb_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int MAX_ADDR_W = 16;
   localparam int MAX_DATA_W = 64;

   typedef struct packed {
      logic [MAX_ADDR_W-1:0] addr;
      logic [MAX_DATA_W-1:0] data;
   } wr_req_t;

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer (with wrap); the pointer moves just past the winner on each grant.
module rr_arb #(
   parameter  int NUM   = 4,
   localparam int PTR_W = (NUM > 1) ? $clog2(NUM) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [NUM-1:0] req,
   output logic [NUM-1:0] gnt
);

   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W-1:0] win;
   logic [PTR_W-1:0] idx;
   logic             hit;
   int               cand;

   always_comb begin
      gnt  = '0;
      hit  = 1'b0;
      win  = '0;
      idx  = '0;
      cand = 0;
      for (int k = 0; k < NUM; k++) begin
         cand = int'(ptr_reg) + k;
         if (cand >= NUM) begin
            cand = cand - NUM;
         end
         idx = PTR_W'(cand);
         if (en && !hit && req[idx]) begin
            hit = 1'b1;
            win = idx;
         end
      end
      if (hit) begin
         gnt[win] = 1'b1;
      end
   end

   // Every grant is a handshake because grants only go to valid requesters.
   always_comb begin
      ptr_next = ptr_reg;
      if (hit) begin
         ptr_next = (win == PTR_W'(NUM - 1)) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/sram_wr_arb.sv
// Front-end for a single-write-port SRAM: zero-fills the array after reset,
// round-robins NUM_WR writers onto the write port, forwards colliding writes.
module sram_wr_arb
   import sram_wr_arb_pkg::*;
#(
   parameter  int NUM_WR = 4,
   parameter  int NUM_R  = 1,
   parameter  int W      = 32,
   parameter  int N      = 8,
   localparam int ADDR_W = addr_w(N)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        wr_vld,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*W-1:0]      wr_data,
   output logic [NUM_WR-1:0]        wr_rdy,
   input  logic [NUM_R-1:0]         rd_en,
   input  logic [NUM_R*ADDR_W-1:0]  rd_addr,
   output logic [NUM_R-1:0]         rd_vld,
   output logic [NUM_R*W-1:0]       rd_data,
   output logic                     init_done,
   output logic                     sram_wen,
   output logic [ADDR_W-1:0]        sram_waddr,
   output logic [W-1:0]             sram_wdata,
   output logic [NUM_R-1:0]         sram_ren,
   output logic [NUM_R*ADDR_W-1:0]  sram_raddr,
   input  logic [NUM_R*W-1:0]       sram_rdata
);

   state_t              state_reg;
   state_t              state_next;
   logic [ADDR_W-1:0]   init_cnt_reg;
   logic [ADDR_W-1:0]   init_cnt_next;
   logic                arb_en;
   logic [NUM_WR-1:0]   gnt;
   wr_req_t             sel_req;
   logic                unused_req_bits;

   logic                sram_wen_reg;
   logic                sram_wen_next;
   logic [ADDR_W-1:0]   sram_waddr_reg;
   logic [ADDR_W-1:0]   sram_waddr_next;
   logic [W-1:0]        sram_wdata_reg;
   logic [W-1:0]        sram_wdata_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= INIT;
         init_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         init_cnt_reg <= init_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      init_cnt_next = init_cnt_reg;
      case (state_reg)
         INIT: begin
            init_cnt_next = init_cnt_reg + 1'b1;
            if (init_cnt_reg == ADDR_W'(N - 1)) begin
               state_next    = RUN;
               init_cnt_next = '0;
            end
         end
         RUN: begin
            state_next = RUN;
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

   always_comb begin
      init_done = (state_reg == RUN);
      arb_en    = (state_reg == RUN);
   end

   rr_arb #(
      .NUM (NUM_WR)
   ) u_rr_arb (
      .clk (clk),
      .rst (rst),
      .en  (arb_en),
      .req (wr_vld),
      .gnt (gnt)
   );

   assign wr_rdy = gnt;

   always_comb begin
      sel_req = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (gnt[i]) begin
            sel_req.addr = MAX_ADDR_W'(wr_addr[i*ADDR_W +: ADDR_W]);
            sel_req.data = MAX_DATA_W'(wr_data[i*W +: W]);
         end
      end
   end

   // Struct bits above ADDR_W / W are zero padding for narrow configurations.
   assign unused_req_bits = ^sel_req;

   always_comb begin
      sram_wen_next   = 1'b0;
      sram_waddr_next = sram_waddr_reg;
      sram_wdata_next = sram_wdata_reg;
      if (state_reg == INIT) begin
         sram_wen_next   = 1'b1;
         sram_waddr_next = init_cnt_reg;
         sram_wdata_next = '0;
      end else if (|gnt) begin
         sram_wen_next   = 1'b1;
         sram_waddr_next = sel_req.addr[ADDR_W-1:0];
         sram_wdata_next = sel_req.data[W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_wen_reg   <= 1'b0;
         sram_waddr_reg <= '0;
         sram_wdata_reg <= '0;
      end else begin
         sram_wen_reg   <= sram_wen_next;
         sram_waddr_reg <= sram_waddr_next;
         sram_wdata_reg <= sram_wdata_next;
      end
   end

   assign sram_wen   = sram_wen_reg;
   assign sram_waddr = sram_waddr_reg;
   assign sram_wdata = sram_wdata_reg;
   assign sram_raddr = rd_addr;

   // A read that meets the write currently at the SRAM would see stale array
   // data one cycle later, so capture the write data and substitute it.
   generate
      for (genvar gi = 0; gi < NUM_R; gi++) begin : g_rd
         logic         rd_vld_reg;
         logic         fwd_reg;
         logic [W-1:0] fwd_data_reg;
         logic         collide;

         assign sram_ren[gi] = rd_en[gi] & init_done;
         assign collide      = sram_ren[gi] && sram_wen_reg &&
                               (rd_addr[gi*ADDR_W +: ADDR_W] == sram_waddr_reg);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_vld_reg   <= 1'b0;
               fwd_reg      <= 1'b0;
               fwd_data_reg <= '0;
            end else begin
               rd_vld_reg   <= sram_ren[gi];
               fwd_reg      <= collide;
               fwd_data_reg <= sram_wdata_reg;
            end
         end

         assign rd_vld[gi]           = rd_vld_reg;
         assign rd_data[gi*W +: W]   = fwd_reg ? fwd_data_reg : sram_rdata[gi*W +: W];
      end
   endgenerate

endmodule

// File: tb/tb_sram_wr_arb.sv
// Bench for sram_wr_arb: SRAM macro model, transaction-level reference model,
// an arbitration vector table, directed corner sequences and random traffic.
module tb_sram_wr_arb;

   localparam int NWR = 4;
   localparam int NR  = 2;
   localparam int DW  = 32;
   localparam int NW  = 8;
   localparam int AW  = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NWR-1:0]    wr_vld;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic [NWR-1:0]    wr_rdy;
   logic [NR-1:0]     rd_en;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR-1:0]     rd_vld;
   logic [NR*DW-1:0]  rd_data;
   logic              init_done;
   logic              sram_wen;
   logic [AW-1:0]     sram_waddr;
   logic [DW-1:0]     sram_wdata;
   logic [NR-1:0]     sram_ren;
   logic [NR*AW-1:0]  sram_raddr;
   logic [NR*DW-1:0]  sram_rdata;

   always #5 clk = ~clk;

   sram_wr_arb #(
      .NUM_WR (NWR),
      .NUM_R  (NR),
      .W      (DW),
      .N      (NW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_vld     (wr_vld),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_rdy     (wr_rdy),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_vld     (rd_vld),
      .rd_data    (rd_data),
      .init_done  (init_done),
      .sram_wen   (sram_wen),
      .sram_waddr (sram_waddr),
      .sram_wdata (sram_wdata),
      .sram_ren   (sram_ren),
      .sram_raddr (sram_raddr),
      .sram_rdata (sram_rdata)
   );

   // SRAM macro: read-before-write, one registered read cycle, garbage at power-up.
   logic [DW-1:0] mem [NW];
   bit            mem_scramble = 1'b1;
   always @(posedge clk) begin
      if (mem_scramble) begin
         for (int a = 0; a < NW; a++) mem[a] <= $urandom;
         mem_scramble <= 1'b0;
      end else if (sram_wen) begin
         mem[sram_waddr] <= sram_wdata;
      end
      for (int g = 0; g < NR; g++)
         if (sram_ren[g]) sram_rdata[g*DW +: DW] <= mem[sram_raddr[g*AW +: AW]];
   end

   // Requesters must hold valid, address and data until their handshake.
   logic [NWR-1:0]    pend_q = '0;
   logic [NWR*AW-1:0] addr_q;
   logic [NWR*DW-1:0] data_q;
   always @(posedge clk) begin
      for (int i = 0; i < NWR; i++)
         if (!rst && pend_q[i])
            assert (wr_vld[i] && wr_addr[i*AW +: AW] == addr_q[i*AW +: AW] &&
                    wr_data[i*DW +: DW] == data_q[i*DW +: DW])
            else $error("requester %0d changed its request before the handshake", i);
      pend_q <= rst ? '0 : (wr_vld & ~wr_rdy);
      addr_q <= wr_addr;
      data_q <= wr_data;
   end

   // Reference model state: what a reader must see, arbitration pointer, cycle count.
   logic [DW-1:0] ref_mem [NW];
   int            ptr_m;
   int            cyc;
   int            last_gnt;
   logic          exp_wen;
   logic [AW-1:0] exp_waddr;
   logic [DW-1:0] exp_wdata;
   logic [NR-1:0] exp_vld;
   logic [DW-1:0] exp_rdata [NR];

   logic [AW-1:0] req_a [NWR];
   logic [DW-1:0] req_d [NWR];

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [NWR-1:0] vld;
      logic [NWR-1:0] rdy;
   } arb_vec_t;
   arb_vec_t tbl [18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NWR; i++) begin
         wr_addr[i*AW +: AW] = req_a[i];
         wr_data[i*DW +: DW] = req_d[i];
      end
   endtask

   task automatic after_tick();
      for (int i = 0; i < NWR; i++)
         if (last_gnt == i) begin
            req_a[i] = AW'($urandom_range(0, NW - 1));
            req_d[i] = $urandom;
         end
   endtask

   // One clock of stimulus: check combinational outputs against the model,
   // advance the model, then check registered outputs after the edge.
   task automatic tick();
      int             w;
      bit             run;
      logic [NWR-1:0] g_exp;
      logic [AW-1:0]  ra;
      #1;
      run = (cyc >= NW);
      w   = -1;
      if (run)
         for (int k = 0; k < NWR; k++)
            if (w < 0 && wr_vld[(ptr_m + k) % NWR]) w = (ptr_m + k) % NWR;
      g_exp = '0;
      if (w >= 0) g_exp[w] = 1'b1;
      chk("wr_rdy", 64'(wr_rdy), 64'(g_exp));
      for (int g = 0; g < NR; g++) begin
         exp_vld[g]   = rd_en[g] && run;
         ra           = rd_addr[g*AW +: AW];
         exp_rdata[g] = ref_mem[ra];
         chk("sram_ren", 64'(sram_ren[g]), 64'(exp_vld[g]));
         if (exp_vld[g]) chk("sram_raddr", 64'(sram_raddr[g*AW +: AW]), 64'(ra));
      end
      if (!run) begin
         exp_wen      = 1'b1;
         exp_waddr    = AW'(cyc);
         exp_wdata    = '0;
         ref_mem[cyc] = '0;
      end else if (w >= 0) begin
         exp_wen            = 1'b1;
         exp_waddr          = wr_addr[w*AW +: AW];
         exp_wdata          = wr_data[w*DW +: DW];
         ref_mem[exp_waddr] = exp_wdata;
         ptr_m              = (w + 1) % NWR;
      end else begin
         exp_wen = 1'b0;
      end
      last_gnt = w;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk("init_done", 64'(init_done), 64'(cyc >= NW));
      chk("sram_wen", 64'(sram_wen), 64'(exp_wen));
      if (exp_wen) begin
         chk("sram_waddr", 64'(sram_waddr), 64'(exp_waddr));
         chk("sram_wdata", 64'(sram_wdata), 64'(exp_wdata));
      end
      for (int g = 0; g < NR; g++) begin
         chk("rd_vld", 64'(rd_vld[g]), 64'(exp_vld[g]));
         if (exp_vld[g]) chk("rd_data", 64'(rd_data[g*DW +: DW]), 64'(exp_rdata[g]));
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      wr_vld = '0;
      rd_en  = '0;
      #1;
      chk("rst_wr_rdy", 64'(wr_rdy), 64'(0));
      chk("rst_rd_vld", 64'(rd_vld), 64'(0));
      chk("rst_init_done", 64'(init_done), 64'(0));
      chk("rst_sram_wen", 64'(sram_wen), 64'(0));
      chk("rst_sram_waddr", 64'(sram_waddr), 64'(0));
      chk("rst_sram_wdata", 64'(sram_wdata), 64'(0));
      chk("rst_sram_ren", 64'(sram_ren), 64'(0));
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold_wen", 64'(sram_wen), 64'(0));
      rst      = 1'b0;
      cyc      = 0;
      ptr_m    = 0;
      last_gnt = -1;
   endtask

   task automatic run_init();
      for (int k = 0; k < NW; k++) begin
         wr_vld  = '0;
         rd_en   = NR'($urandom);
         rd_addr = (NR*AW)'($urandom);
         drive();
         tick();
      end
   endtask

   initial begin
      tbl[0]  = '{4'b1111, 4'b0001};
      tbl[1]  = '{4'b1111, 4'b0010};
      tbl[2]  = '{4'b1111, 4'b0100};
      tbl[3]  = '{4'b1111, 4'b1000};
      tbl[4]  = '{4'b1111, 4'b0001};
      tbl[5]  = '{4'b1110, 4'b0010};
      tbl[6]  = '{4'b1100, 4'b0100};
      tbl[7]  = '{4'b1000, 4'b1000};
      tbl[8]  = '{4'b0010, 4'b0010};
      tbl[9]  = '{4'b1010, 4'b1000};
      tbl[10] = '{4'b1010, 4'b0010};
      tbl[11] = '{4'b1010, 4'b1000};
      tbl[12] = '{4'b0010, 4'b0010};
      tbl[13] = '{4'b0000, 4'b0000};
      tbl[14] = '{4'b0100, 4'b0100};
      tbl[15] = '{4'b0100, 4'b0100};
      tbl[16] = '{4'b0100, 4'b0100};
      tbl[17] = '{4'b0000, 4'b0000};

      for (int i = 0; i < NWR; i++) begin
         req_a[i] = AW'($urandom_range(0, NW - 1));
         req_d[i] = $urandom;
      end
      wr_vld  = '0;
      rd_en   = '0;
      rd_addr = '0;
      drive();

      // Reset, zero-fill, then every address reads back 0.
      do_reset();
      run_init();
      for (int k = 0; k < NW / 2; k++) begin
         wr_vld  = '0;
         rd_en   = 2'b11;
         rd_addr = {AW'(2*k + 1), AW'(2*k)};
         drive();
         tick();
         chk("zero_p0", 64'(rd_data[0 +: DW]), 64'(0));
         chk("zero_p1", 64'(rd_data[DW +: DW]), 64'(0));
      end

      // Arbitration table, pointer starts at 0 after reset.
      for (int k = 0; k < 18; k++) begin
         wr_vld  = tbl[k].vld;
         rd_en   = NR'($urandom);
         rd_addr = (NR*AW)'($urandom);
         drive();
         #1;
         chk("tbl_wr_rdy", 64'(wr_rdy), 64'(tbl[k].rdy));
         tick();
         after_tick();
      end

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < NWR; i++)
            if (last_gnt == i)      wr_vld[i] = ($urandom_range(0, 3) != 0);
            else if (!wr_vld[i])    wr_vld[i] = ($urandom_range(0, 2) == 0);
         rd_en   = NR'($urandom);
         rd_addr = (NR*AW)'($urandom);
         drive();
         tick();
         after_tick();
      end

      // Reset in the middle of INIT restarts the fill from address 0.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         wr_vld = '0;
         rd_en  = '0;
         drive();
         tick();
      end
      do_reset();
      run_init();

      // Forwarding and read/write ordering on a freshly zeroed array.
      req_a[2] = 3'd4; req_d[2] = 32'h4444_4444;
      wr_vld = 4'b0100; rd_en = '0; drive(); tick(); after_tick();
      wr_vld = '0; drive(); tick();
      req_a[0] = 3'd5; req_d[0] = 32'hA5A5_A5A5;
      wr_vld = 4'b0001; rd_en = 2'b01; rd_addr = {3'd0, 3'd5}; drive(); tick(); after_tick();
      chk("rd_same_cycle_old", 64'(rd_data[0 +: DW]), 64'(0));
      wr_vld = '0; rd_en = 2'b01; rd_addr = {3'd0, 3'd5}; drive(); tick();
      chk("rd_fwd_a5", 64'(rd_data[0 +: DW]), 64'h0000_0000_A5A5_A5A5);
      req_a[1] = 3'd3; req_d[1] = 32'h33CC_33CC;
      wr_vld = 4'b0010; rd_en = '0; drive(); tick(); after_tick();
      wr_vld = '0; rd_en = 2'b11; rd_addr = {3'd4, 3'd3}; drive(); tick();
      chk("rd_fwd_p0", 64'(rd_data[0 +: DW]), 64'h0000_0000_33CC_33CC);
      chk("rd_array_p1", 64'(rd_data[DW +: DW]), 64'h0000_0000_4444_4444);
      rd_en = 2'b01; rd_addr = {3'd0, 3'd5}; drive(); tick();
      chk("rd_array_a5", 64'(rd_data[0 +: DW]), 64'h0000_0000_A5A5_A5A5);

      // Reset with an accept pending: the staged write must be discarded.
      do_reset();
      run_init();
      req_a[0] = 3'd6; req_d[0] = 32'h1234_5678;
      wr_vld = 4'b0001; rd_en = '0; drive();
      #1;
      chk("pend_wr_rdy", 64'(wr_rdy), 64'(4'b0001));
      do_reset();
      run_init();
      wr_vld = '0; rd_en = 2'b01; rd_addr = {3'd0, 3'd6}; drive(); tick();
      chk("pend_discarded", 64'(rd_data[0 +: DW]), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_wr_arb.md
Name: sram_wr_arb

Overview:
- Front-end controller for the 1-read-port-per-bank, single-write-port SRAM macro, built from `dpsram` banks with one registered read cycle.
- Arbitrates NUM_WR independent write requesters onto the single SRAM write port using round-robin valid/ready handshakes.
- Zero-initialises the whole array after reset.
- Forwards write data to any read that collides with an in-flight write to the same address, so readers always see coherent data.

Parameters:
- NUM_WR, 4: number of write requesters (>=1).
- NUM_R, 1: number of read ports (matches the SRAM read-port count).
- W, 32: data word width.
- N, 8: number of words; ADDR_W = $clog2(N).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wr_vld  in  NUM_WR  per-requester write valid
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses, requester i at [i*ADDR_W+:ADDR_W]
- wr_data  in  NUM_WR*W  packed write data
- wr_rdy  out  NUM_WR  per-requester accept; one-hot or zero
- rd_en  in  NUM_R  read request per port
- rd_addr  in  NUM_R*ADDR_W  packed read addresses
- rd_vld  out  NUM_R  read data valid, one cycle after an accepted read
- rd_data  out  NUM_R*W  coherent read data
- init_done  out  1  high once zero-initialisation completes
- sram_wen  out  1  to SRAM write enable
- sram_waddr  out  ADDR_W  to SRAM write address
- sram_wdata  out  W  to SRAM write data
- sram_ren  out  NUM_R  to SRAM read enables
- sram_raddr  out  NUM_R*ADDR_W  to SRAM read addresses
- sram_rdata  in  NUM_R*W  from SRAM; valid the cycle after sram_ren

Behaviour:
- FSM has two states: INIT and RUN. Reset enters INIT with init_cnt=0.
- INIT:
  - Each cycle the registered write port drives wen=1, waddr=init_cnt, wdata=0.
  - init_cnt increments each cycle; after writing N-1, next state is RUN.
  - Takes exactly N cycles; init_done rises on the first RUN cycle.
  - wr_rdy=0 and sram_ren=0; rd_en is ignored (no rd_vld).
- RUN, arbitration:
  - Combinational round-robin: the grant goes to the first requester with wr_vld, searching from rr_ptr upward, with wrap.
  - wr_rdy = grant. A handshake is wr_vld[i] && wr_rdy[i].
  - On a handshake, rr_ptr <= (winner+1) mod NUM_WR; otherwise rr_ptr holds.
  - At most one handshake per cycle, so sustained throughput is one write per cycle.
- Write stage:
  - sram_wen/waddr/wdata are registered. An accept at cycle t drives the SRAM at t+1; accept-to-array latency is 1 cycle.
  - sram_wen=0 in any cycle with no accept.
- Reads:
  - sram_ren = rd_en gated by init_done; sram_raddr = rd_addr (combinational pass-through).
  - rd_vld[g] is registered from sram_ren[g] (latency 1).
- Forwarding (collision):
  - If at cycle t sram_ren[g] && sram_wen && sram_raddr[g]==sram_waddr, flop fwd[g]=1 and fwd_data[g]=sram_wdata.
  - At t+1, rd_data[g] = fwd[g] ? fwd_data[g] : sram_rdata[g].
  - A write accepted at cycle t (not yet at the SRAM) is not visible to a read issued at t. The read returns the prior array contents; this is the defined ordering.
- Reset values: wr_rdy=0, rd_vld=0, init_done=0, sram_wen=0, sram_waddr=0, sram_wdata=0, rr_ptr=0, fwd=0.
- Reset mid-operation (INIT or RUN) discards the pending staged write, restarts INIT from 0, and drops any outstanding rd_vld.
- Single requester holding wr_vld is granted every cycle.
- Requester data/address must stay stable while wr_vld is high and wr_rdy is low; wr_vld must not drop before the handshake (asserted in the bench).

Decomposition:
- Package sram_wr_arb_pkg holds:
  - state enum {INIT, RUN};
  - ADDR_W helper function;
  - write-request struct {addr, data}.
- One natural sub-module: rr_arb, a parameterised round-robin arbiter (NUM_WR requests, pointer update on accept, one-hot grant). It is reusable by other sharing blocks.

Test Plan:
- Reset, N=8 -> sram_wen high for exactly 8 cycles with addrs 0..7 and data 0; init_done rises at cycle 8; reads of every address then return 0.
- All 4 requesters hold wr_vld continuously from init_done -> grants 0,1,2,3,0,1,... one per cycle; sram_wen continuous; no requester starves.
- Requesters 1 and 3 only, starting at rr_ptr=2 -> first grant 3, then 1, then 3.
- Write addr 5 data 0xA5A5A5A5 accepted at t; read addr 5 issued at t+1 -> rd_data at t+2 = 0xA5A5A5A5 (forwarded); read issued at t returns 0.
- NUM_R=2, both ports read addr 3 and addr 4 in the SRAM-write cycle for addr 3 -> port0 gets the forwarded new data; port1 gets the array data for addr 4.
- Assert rst mid-INIT (cycle 4) and again mid-RUN with a pending accept -> all outputs return to reset values; INIT restarts at addr 0; the pending write never reaches the SRAM.
